// File: rtl/traffic_checker_if.sv
`default_nettype none
//============================================================================
// Module      : traffic_checker_if
// Description : Valid/ready word stream from a depacketizer into the
//               traffic checker. The master drives data and valid, the
//               slave (checker) drives ready.
//   i_data_in   : WIDTH_DATA-bit payload word
//   i_valid_in  : payload word is valid
//   i_ready_out : consumer can accept a word this cycle
// Revision    : 1.0 - initial release
//============================================================================
interface traffic_checker_if #(
    parameter int WIDTH_DATA = 100
);
    logic [WIDTH_DATA-1:0] i_data_in;
    logic                  i_valid_in;
    logic                  i_ready_out;

    modport master (
        output i_data_in,
        output i_valid_in,
        input  i_ready_out
    );

    modport slave (
        input  i_data_in,
        input  i_valid_in,
        output i_ready_out
    );
endinterface
`default_nettype wire

// File: rtl/traffic_checker.sv
`default_nettype none
//============================================================================
// Module      : traffic_checker
// Description : Consumer end of the fabricport traffic path. Accepts words
//               under valid/ready with pseudo-random backpressure, regenerates
//               the producer's seeded LFSR sequence and checks every word.
// Ports       :
//   clk             : single clock
//   rst             : synchronous active-high reset
//   i_start         : pulse, begins/restarts a run from IDLE or DONE
//   bus (slave)     : i_data_in / i_valid_in in, i_ready_out out (registered)
//   o_done          : run finished (complete or timeout)
//   o_pass          : done with no errors and no timeout
//   o_timeout       : run aborted after TIMEOUT idle RUN cycles
//   o_rx_count      : words accepted this run
//   o_err_count     : mismatching words, saturating
//   o_first_err_idx : 0-based index of first mismatch (0 if none)
//   o_cycle_count   : cycles from first to last transfer, inclusive
// Revision    : 1.0 - initial release
//============================================================================
module traffic_checker #(
    parameter int          WIDTH_DATA   = 100,
    parameter int          N_EXPECTED   = 1000,
    parameter logic [31:0] SEED         = 32'hBAADF00D,
    parameter int          STALL_FACTOR = 15,
    parameter int          TIMEOUT      = 1024,
    localparam int         CNT_W        = $clog2(N_EXPECTED+1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_start,
    traffic_checker_if.slave      bus,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [CNT_W-1:0]      o_rx_count,
    output logic [CNT_W-1:0]      o_err_count,
    output logic [CNT_W-1:0]      o_first_err_idx,
    output logic [31:0]           o_cycle_count
);
    localparam int          IDLE_W        = $clog2(TIMEOUT+1);
    localparam int          C_REP         = (WIDTH_DATA + 31) / 32;
    localparam logic [31:0] C_MASK        = 32'h80200003;
    localparam logic [31:0] C_DATA_SEED   = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] C_STALL_RAW   = SEED ^ 32'h5A5A5A5A;
    localparam logic [31:0] C_STALL_SEED  = (C_STALL_RAW == 32'h0) ? 32'h1 : C_STALL_RAW;
    localparam logic [31:0] C_STALL_THR   = 32'(STALL_FACTOR);
    localparam logic [CNT_W-1:0]  C_N     = CNT_W'(N_EXPECTED);
    localparam logic [IDLE_W-1:0] C_TO    = IDLE_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // 32-bit Galois LFSR, right shift, mask applied when the shifted-out bit is 1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? C_MASK : 32'h0);
    endfunction

    logic [1:0]        r_state;
    logic [31:0]       r_data_lfsr;
    logic [31:0]       r_stall_lfsr;
    logic              r_ready;
    logic [CNT_W-1:0]  r_rx;
    logic [CNT_W-1:0]  r_err;
    logic [CNT_W-1:0]  r_fei;
    logic [31:0]       r_cyc;
    logic [IDLE_W-1:0] r_idle;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;

    logic [C_REP*32-1:0]   w_rep;
    logic [WIDTH_DATA-1:0] w_expected;
    logic                  w_run;
    logic                  w_xfer;
    logic                  w_mismatch;
    logic [CNT_W-1:0]      w_rx_inc;
    logic [CNT_W-1:0]      w_err_next;
    logic [IDLE_W-1:0]     w_idle_inc;
    logic                  w_complete;
    logic                  w_expire;
    logic                  w_start_run;
    logic [1:0]            w_next_state;
    logic [31:0]           w_stall_next;
    logic                  w_ready_next;

    assign w_rep       = {C_REP{r_data_lfsr}};
    assign w_expected  = w_rep[WIDTH_DATA-1:0];
    assign w_run       = (r_state == S_RUN);
    assign w_xfer      = w_run & bus.i_valid_in & r_ready;
    assign w_mismatch  = w_xfer & (bus.i_data_in != w_expected);
    assign w_rx_inc    = r_rx + CNT_W'(1);
    assign w_err_next  = (w_mismatch && !(&r_err)) ? r_err + CNT_W'(1) : r_err;
    assign w_idle_inc  = r_idle + IDLE_W'(1);
    assign w_complete  = w_xfer && (w_rx_inc == C_N);
    // A transfer clears the idle counter, so completion and expiry never coincide
    assign w_expire    = w_run && !w_xfer && (w_idle_inc == C_TO);
    assign w_start_run = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_RUN;
            S_RUN:   if (w_complete || w_expire) w_next_state = S_DONE;
            S_DONE:  if (i_start) w_next_state = S_RUN;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Ready is registered: it is computed from the stall LFSR value that
    // will be current in the next cycle, so the first RUN cycle uses the seed
    assign w_stall_next = w_start_run ? C_STALL_SEED :
                          (w_run ? lfsr_step(r_stall_lfsr) : r_stall_lfsr);
    assign w_ready_next = (w_next_state == S_RUN) &&
                          ({28'd0, w_stall_next[3:0]} <= C_STALL_THR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_data_lfsr  <= C_DATA_SEED;
            r_stall_lfsr <= C_STALL_SEED;
            r_ready      <= 1'b0;
            r_rx         <= '0;
            r_err        <= '0;
            r_fei        <= '0;
            r_cyc        <= '0;
            r_idle       <= '0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_stall_lfsr <= w_stall_next;
            r_ready      <= w_ready_next;
            if (w_start_run) begin
                r_data_lfsr <= C_DATA_SEED;
                r_rx        <= '0;
                r_err       <= '0;
                r_fei       <= '0;
                r_cyc       <= '0;
                r_idle      <= '0;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
                r_timeout   <= 1'b0;
            end else if (w_run) begin
                if (w_xfer) begin
                    r_data_lfsr <= lfsr_step(r_data_lfsr);
                    r_rx        <= w_rx_inc;
                    r_err       <= w_err_next;
                    r_idle      <= '0;
                    if (w_mismatch && (r_err == '0))
                        r_fei <= r_rx;
                    // Throughput window opens on the first accepted word
                    r_cyc <= (r_rx == '0) ? 32'd1 : r_cyc + 32'd1;
                end else begin
                    r_idle <= w_idle_inc;
                    if (r_rx != '0)
                        r_cyc <= r_cyc + 32'd1;
                end
                if (w_complete) begin
                    r_done <= 1'b1;
                    r_pass <= (w_err_next == '0);
                end else if (w_expire) begin
                    r_done    <= 1'b1;
                    r_timeout <= 1'b1;
                    r_pass    <= 1'b0;
                end
            end
        end
    end

    assign bus.i_ready_out  = r_ready;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_timeout        = r_timeout;
    assign o_rx_count       = r_rx;
    assign o_err_count      = r_err;
    assign o_first_err_idx  = r_fei;
    assign o_cycle_count    = r_cyc;
endmodule
`default_nettype wire

// File: tb/tb_traffic_checker.sv
`default_nettype none
//============================================================================
// Module      : tb_traffic_checker
// Description : Directed self-checking bench for traffic_checker. Three
//               instances cover the default configuration, a stalling
//               configuration and a short-timeout configuration; a selector
//               routes the shared source to one instance at a time.
// Revision    : 1.0 - initial release
//============================================================================
module tb_traffic_checker;
    localparam int          W     = 100;
    localparam int          N     = 1000;
    localparam logic [31:0] SEED  = 32'hBAADF00D;
    localparam logic [31:0] MASK  = 32'h80200003;

    logic clk;
    logic rst;
    logic tb_start;
    logic tb_valid;
    logic [W-1:0] tb_data;
    int   sel;

    logic [2:0]       start_v;
    logic [2:0]       done_v;
    logic [2:0]       pass_v;
    logic [2:0]       to_v;
    logic [2:0]       rdy_v;
    logic [2:0][9:0]  rx_v;
    logic [2:0][9:0]  err_v;
    logic [2:0][9:0]  fei_v;
    logic [2:0][31:0] cyc_v;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_checker_if #(.WIDTH_DATA(W)) if_a ();
    traffic_checker_if #(.WIDTH_DATA(W)) if_b ();
    traffic_checker_if #(.WIDTH_DATA(W)) if_c ();

    assign if_a.i_data_in  = tb_data;
    assign if_b.i_data_in  = tb_data;
    assign if_c.i_data_in  = tb_data;
    assign if_a.i_valid_in = tb_valid && (sel == 0);
    assign if_b.i_valid_in = tb_valid && (sel == 1);
    assign if_c.i_valid_in = tb_valid && (sel == 2);
    assign start_v[0]      = tb_start && (sel == 0);
    assign start_v[1]      = tb_start && (sel == 1);
    assign start_v[2]      = tb_start && (sel == 2);
    assign rdy_v[0]        = if_a.i_ready_out;
    assign rdy_v[1]        = if_b.i_ready_out;
    assign rdy_v[2]        = if_c.i_ready_out;

    traffic_checker #(.WIDTH_DATA(W), .N_EXPECTED(N), .SEED(SEED),
                      .STALL_FACTOR(15), .TIMEOUT(1024)) u_a (
        .clk(clk), .rst(rst), .i_start(start_v[0]), .bus(if_a.slave),
        .o_done(done_v[0]), .o_pass(pass_v[0]), .o_timeout(to_v[0]),
        .o_rx_count(rx_v[0]), .o_err_count(err_v[0]),
        .o_first_err_idx(fei_v[0]), .o_cycle_count(cyc_v[0]));

    traffic_checker #(.WIDTH_DATA(W), .N_EXPECTED(N), .SEED(SEED),
                      .STALL_FACTOR(7), .TIMEOUT(1024)) u_b (
        .clk(clk), .rst(rst), .i_start(start_v[1]), .bus(if_b.slave),
        .o_done(done_v[1]), .o_pass(pass_v[1]), .o_timeout(to_v[1]),
        .o_rx_count(rx_v[1]), .o_err_count(err_v[1]),
        .o_first_err_idx(fei_v[1]), .o_cycle_count(cyc_v[1]));

    traffic_checker #(.WIDTH_DATA(W), .N_EXPECTED(N), .SEED(SEED),
                      .STALL_FACTOR(15), .TIMEOUT(64)) u_c (
        .clk(clk), .rst(rst), .i_start(start_v[2]), .bus(if_c.slave),
        .o_done(done_v[2]), .o_pass(pass_v[2]), .o_timeout(to_v[2]),
        .o_rx_count(rx_v[2]), .o_err_count(err_v[2]),
        .o_first_err_idx(fei_v[2]), .o_cycle_count(cyc_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? MASK : 32'h0);
    endfunction

    function automatic logic [W-1:0] word_of(input logic [31:0] s);
        logic [127:0] r;
        r = {4{s}};
        return r[W-1:0];
    endfunction

    task automatic pulse_start();
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
    endtask

    // Producer: holds each word until accepted. Ready is registered, so its
    // value at the falling edge is the value seen by the next rising edge.
    task automatic run_words(input int n, input int bad_idx, input int max_cycles,
                             output int cycles, output int ready_low);
        logic [31:0] m;
        int idx;
        logic acc;
        m = SEED; idx = 0; cycles = 0; ready_low = 0;
        tb_valid = 1'b1;
        tb_data  = word_of(m) ^ ((bad_idx == 0) ? W'(1) : W'(0));
        while (idx < n && cycles < max_cycles) begin
            acc = rdy_v[sel];
            if (!acc) ready_low++;
            @(negedge clk);
            cycles++;
            if (acc) begin
                idx++;
                m = lfsr_step(m);
                if (idx < n)
                    tb_data = word_of(m) ^ ((bad_idx == idx) ? W'(1) : W'(0));
                else
                    tb_valid = 1'b0;
            end
        end
        tb_valid = 1'b0;
        check("words_sent", idx, n);
    endtask

    initial begin
        int cyc;
        int low;
        rst = 1'b1; tb_start = 1'b0; tb_valid = 1'b0; tb_data = '0; sel = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_done",    done_v[0], 0);
        check("rst_pass",    pass_v[0], 0);
        check("rst_timeout", to_v[0],   0);
        check("rst_ready",   rdy_v[0],  0);
        check("rst_rx",      rx_v[0],   0);
        check("rst_cyc",     cyc_v[0],  0);

        // Valid with garbage in IDLE is ignored
        tb_valid = 1'b1; tb_data = '1;
        repeat (4) @(negedge clk);
        tb_valid = 1'b0;
        check("idle_rx",    rx_v[0],   0);
        check("idle_ready", rdy_v[0],  0);
        check("idle_done",  done_v[0], 0);

        // 1: clean back-to-back run
        pulse_start();
        check("t1_first_ready", rdy_v[0], 1);
        run_words(N, -1, 5000, cyc, low);
        check("t1_done",  done_v[0], 1);
        check("t1_pass",  pass_v[0], 1);
        check("t1_to",    to_v[0],   0);
        check("t1_rx",    rx_v[0],   N);
        check("t1_err",   err_v[0],  0);
        check("t1_fei",   fei_v[0],  0);
        check("t1_cyc",   cyc_v[0],  N);
        check("t1_ready", rdy_v[0],  0);

        // 2: bit 0 of word 5 corrupted
        pulse_start();
        run_words(N, 5, 5000, cyc, low);
        check("t2_done", done_v[0], 1);
        check("t2_pass", pass_v[0], 0);
        check("t2_rx",   rx_v[0],   N);
        check("t2_err",  err_v[0],  1);
        check("t2_fei",  fei_v[0],  5);

        // 6: valid with garbage in DONE is ignored, start clears, rerun passes
        tb_valid = 1'b1; tb_data = '0;
        repeat (4) @(negedge clk);
        tb_valid = 1'b0;
        check("t6_hold_rx",   rx_v[0],  N);
        check("t6_hold_err",  err_v[0], 1);
        check("t6_hold_done", done_v[0], 1);
        pulse_start();
        check("t6_clr_done", done_v[0], 0);
        check("t6_clr_rx",   rx_v[0],   0);
        check("t6_clr_err",  err_v[0],  0);
        check("t6_clr_fei",  fei_v[0],  0);
        run_words(N, -1, 5000, cyc, low);
        check("t6_pass", pass_v[0], 1);
        check("t6_rx",   rx_v[0],   N);

        // 5: reset mid-run, then a fresh run
        pulse_start();
        run_words(300, -1, 5000, cyc, low);
        check("t5_mid_rx",   rx_v[0],   300);
        check("t5_mid_done", done_v[0], 0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_rx",    rx_v[0],   0);
        check("t5_rst_cyc",   cyc_v[0],  0);
        check("t5_rst_ready", rdy_v[0],  0);
        check("t5_rst_done",  done_v[0], 0);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        run_words(N, -1, 5000, cyc, low);
        check("t5_pass", pass_v[0], 1);
        check("t5_rx",   rx_v[0],   N);

        // 3: random backpressure, ready low roughly half the time
        sel = 1;
        pulse_start();
        run_words(N, -1, 8000, cyc, low);
        check("t3_done",    done_v[1], 1);
        check("t3_pass",    pass_v[1], 1);
        check("t3_rx",      rx_v[1],   N);
        check("t3_cyc_gt",  (cyc_v[1] > 32'd1000), 1);
        check("t3_low_mid", ((low * 10 >= cyc * 3) && (low * 10 <= cyc * 7)), 1);

        // 4: source stops after 10 words, timeout after 64 idle cycles
        sel = 2;
        pulse_start();
        run_words(10, -1, 100, cyc, low);
        repeat (63) @(negedge clk);
        check("t4_pre_done", done_v[2], 0);
        @(negedge clk);
        check("t4_done", done_v[2], 1);
        check("t4_to",   to_v[2],   1);
        check("t4_pass", pass_v[2], 0);
        check("t4_rx",   rx_v[2],   10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
